// File: rtl/neuron_layer_scheduler.sv
// Time-multiplexes N_NEURONS neurons onto one external combinational neuron datapath.
// Optional spike counter: define SCHED_SPIKE_COUNT_EN to enable spike_count accumulation.
module neuron_layer_scheduler #(
  parameter int N_NEURONS   = 4,
  parameter int n_stage     = 3,
  parameter int n_membrane  = n_stage + 2,
  parameter int n_threshold = n_membrane - 1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          step_valid,
  output logic                          step_ready,
  input  logic [2**n_stage-1:0]         step_inputs,
  input  logic                          cfg_we,
  input  logic [$clog2(N_NEURONS)-1:0]  cfg_addr,
  input  logic [2**n_stage-1:0]         cfg_weights,
  input  logic [2:0]                    shift,
  input  logic [n_threshold-1:0]        threshold,
  output logic [2**n_stage-1:0]         dp_inputs,
  output logic [2**n_stage-1:0]         dp_weights,
  output logic [2:0]                    dp_shift,
  output logic [n_threshold-1:0]        dp_threshold,
  output logic signed [n_membrane-1:0]  dp_last_membrane,
  output logic                          dp_was_spike,
  input  logic signed [n_membrane-1:0]  dp_new_membrane,
  input  logic                          dp_is_spike,
  output logic [N_NEURONS-1:0]          spikes,
  output logic                          spikes_valid,
  output logic                          busy,
  output logic [15:0]                   spike_count
);

  localparam int N_SYN = 2 ** n_stage;
  localparam int IDX_W = $clog2(N_NEURONS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_NEURONS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                       state;
  logic [IDX_W-1:0]             index;
  logic [N_SYN-1:0]             inputs_q;
  logic [N_SYN-1:0]             weights_q  [N_NEURONS];
  logic signed [n_membrane-1:0] membrane_q [N_NEURONS];
  logic [N_NEURONS-1:0]         was_spike_q;
  logic [N_NEURONS-1:0]         result_q;
  logic [N_NEURONS-1:0]         result_next;
  logic [IDX_W-1:0]             sel;

  // Outside RUN the datapath still sees neuron 0 so its outputs stay defined.
  assign sel = (state == RUN) ? index : '0;

  assign dp_inputs        = inputs_q;
  assign dp_weights       = weights_q[sel];
  assign dp_last_membrane = membrane_q[sel];
  assign dp_was_spike     = was_spike_q[sel];
  assign dp_shift         = shift;
  assign dp_threshold     = threshold;

  assign step_ready = (state == IDLE) && !reset;
  assign busy       = (state != IDLE);

  // Result vector including the neuron being evaluated this cycle.
  always_comb begin
    result_next        = result_q;
    result_next[index] = dp_is_spike;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      index        <= '0;
      inputs_q     <= '0;
      was_spike_q  <= '0;
      result_q     <= '0;
      spikes       <= '0;
      spikes_valid <= 1'b0;
      for (int i = 0; i < N_NEURONS; i++) begin
        weights_q[i]  <= '0;
        membrane_q[i] <= '0;
      end
    end else begin
      spikes_valid <= 1'b0;
      unique case (state)
        IDLE: begin
          // A same-cycle weight write lands before the step's first RUN read.
          if (cfg_we && (int'(cfg_addr) < N_NEURONS)) begin
            weights_q[cfg_addr] <= cfg_weights;
          end
          if (step_valid && step_ready) begin
            inputs_q <= step_inputs;
            index    <= '0;
            result_q <= '0;
            state    <= RUN;
          end
        end
        RUN: begin
          membrane_q[index]  <= dp_new_membrane;
          was_spike_q[index] <= dp_is_spike;
          result_q           <= result_next;
          if (index == LAST_IDX) begin
            spikes       <= result_next;
            spikes_valid <= 1'b1;
            state        <= DONE;
          end else begin
            index <= index + 1'b1;
          end
        end
        DONE: begin
          index <= '0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef SCHED_SPIKE_COUNT_EN
  localparam int POP_W = $clog2(N_NEURONS + 1);

  logic [15:0]      count_q;
  logic [POP_W-1:0] pop;
  logic [16:0]      count_sum;

  always_comb begin
    pop = '0;
    for (int i = 0; i < N_NEURONS; i++) begin
      pop = pop + POP_W'(spikes[i]);
    end
    count_sum = {1'b0, count_q} + 17'(pop);
  end

  // spikes already holds the finished result while in DONE.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else if (state == DONE) begin
      count_q <= count_sum[16] ? 16'hFFFF : count_sum[15:0];
    end
  end

  assign spike_count = count_q;
`else
  assign spike_count = 16'd0;
`endif

endmodule

// File: tb/tb_neuron_layer_scheduler.sv
// Scoreboard bench for neuron_layer_scheduler with a stub datapath (new = last+1, spike = new >= threshold).
module tb_neuron_layer_scheduler;

  localparam int N    = 4;
  localparam int NS   = 3;
  localparam int SYN  = 8;
  localparam int MEMW = 5;
  localparam int THRW = 4;

  logic                   clk = 1'b0;
  logic                   reset = 1'b1;
  logic                   step_valid = 1'b0;
  logic                   step_ready;
  logic [SYN-1:0]         step_inputs = '0;
  logic                   cfg_we = 1'b0;
  logic [1:0]             cfg_addr = '0;
  logic [SYN-1:0]         cfg_weights = '0;
  logic [2:0]             shift = '0;
  logic [THRW-1:0]        threshold = '0;
  logic [SYN-1:0]         dp_inputs, dp_weights;
  logic [2:0]             dp_shift;
  logic [THRW-1:0]        dp_threshold;
  logic signed [MEMW-1:0] dp_last_membrane;
  logic                   dp_was_spike;
  logic signed [MEMW-1:0] dp_new_membrane;
  logic                   dp_is_spike;
  logic [N-1:0]           spikes;
  logic                   spikes_valid;
  logic                   busy;
  logic [15:0]            spike_count;

  always #5 clk = ~clk;

  neuron_layer_scheduler #(.N_NEURONS(N), .n_stage(NS)) dut (
    .clk(clk), .reset(reset),
    .step_valid(step_valid), .step_ready(step_ready), .step_inputs(step_inputs),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_weights(cfg_weights),
    .shift(shift), .threshold(threshold),
    .dp_inputs(dp_inputs), .dp_weights(dp_weights), .dp_shift(dp_shift),
    .dp_threshold(dp_threshold), .dp_last_membrane(dp_last_membrane),
    .dp_was_spike(dp_was_spike), .dp_new_membrane(dp_new_membrane),
    .dp_is_spike(dp_is_spike), .spikes(spikes), .spikes_valid(spikes_valid),
    .busy(busy), .spike_count(spike_count)
  );

  // Stub neuron datapath.
  assign dp_new_membrane = dp_last_membrane + 5'sd1;
  assign dp_is_spike     = (dp_new_membrane >= $signed({1'b0, dp_threshold}));

  typedef struct {
    logic [SYN-1:0] w;
    int             mem;
    logic           ws;
    logic [SYN-1:0] inp;
    logic [2:0]     sh;
    logic [THRW-1:0] thr;
  } dp_exp_t;

  dp_exp_t      dp_q[$];
  logic [N-1:0] spk_q[$];
  int           cnt_q[$];

  logic [SYN-1:0] m_w[N];
  int             m_mem[N];
  logic           m_ws[N];
  int             m_count;

  int n_checks = 0;
  int n_fail   = 0;
  bit prev_valid = 1'b0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic failNow(input string name);
    n_checks++;
    n_fail++;
    $display("[TB] FAIL %s: got unexpected DUT activity expected none at %0t", name, $time);
  endtask

  task automatic modelReset();
    for (int i = 0; i < N; i++) begin
      m_w[i] = '0; m_mem[i] = 0; m_ws[i] = 1'b0;
    end
    m_count = 0;
    dp_q.delete(); spk_q.delete(); cnt_q.delete();
  endtask

  // One time step: every neuron's membrane goes up by one and fires at threshold.
  task automatic modelStep(input logic [SYN-1:0] inp, input logic [2:0] sh, input logic [THRW-1:0] thr);
    logic [N-1:0] res;
    dp_exp_t e;
    res = '0;
    for (int i = 0; i < N; i++) begin
      e.w = m_w[i]; e.mem = m_mem[i]; e.ws = m_ws[i]; e.inp = inp; e.sh = sh; e.thr = thr;
      dp_q.push_back(e);
      m_mem[i] = m_mem[i] + 1;
      res[i]   = (m_mem[i] >= int'(thr));
      m_ws[i]  = res[i];
    end
    spk_q.push_back(res);
`ifdef SCHED_SPIKE_COUNT_EN
    m_count = m_count + $countones(res);
    if (m_count > 65535) m_count = 65535;
`endif
    cnt_q.push_back(m_count);
  endtask

  // Waits for IDLE, then issues an optional weight write and/or a step in one cycle.
  task automatic applyStimulus(input logic do_cfg, input logic [1:0] addr, input logic [SYN-1:0] w,
                               input logic do_step, input logic [SYN-1:0] inp,
                               input logic [2:0] sh, input logic [THRW-1:0] thr);
    int waited = 0;
    while (!step_ready && waited < 100) begin
      @(posedge clk); #1;
      waited++;
    end
    if (waited >= 100) checkOutput("ready_timeout", 32'(step_ready), 32'd1);
    cfg_we = do_cfg; cfg_addr = addr; cfg_weights = w;
    if (do_step) begin
      step_valid = 1'b1; step_inputs = inp; shift = sh; threshold = thr;
    end
    @(posedge clk); #1;
    cfg_we = 1'b0; step_valid = 1'b0;
    if (do_cfg) m_w[addr] = w;
    if (do_step) modelStep(inp, sh, thr);
  endtask

  task automatic cfgDuringRun(input logic [1:0] addr, input logic [SYN-1:0] w);
    cfg_we = 1'b1; cfg_addr = addr; cfg_weights = w;
    @(posedge clk); #1;
    cfg_we = 1'b0;
  endtask

  task automatic doReset();
    int waited = 0;
    while (!step_ready && waited < 100) begin
      @(posedge clk); #1;
      waited++;
    end
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    modelReset();
  endtask

  // Monitor: pops expectations whenever the DUT presents a RUN cycle or a result.
  always @(negedge clk) begin
    if (reset) begin
      prev_valid = 1'b0;
    end else begin
      if (prev_valid) begin
        if (cnt_q.size() == 0) failNow("count_unexpected");
        else checkOutput("spike_count", 32'(spike_count), 32'(cnt_q.pop_front()));
      end
      prev_valid = spikes_valid;
      if (busy && !spikes_valid) begin
        if (dp_q.size() == 0) begin
          failNow("run_unexpected");
        end else begin
          dp_exp_t e;
          e = dp_q.pop_front();
          checkOutput("dp_weights", 32'(dp_weights), 32'(e.w));
          checkOutput("dp_last_membrane", 32'(int'(dp_last_membrane)), 32'(e.mem));
          checkOutput("dp_was_spike", 32'(dp_was_spike), 32'(e.ws));
          checkOutput("dp_inputs", 32'(dp_inputs), 32'(e.inp));
          checkOutput("dp_shift", 32'(dp_shift), 32'(e.sh));
          checkOutput("dp_threshold", 32'(dp_threshold), 32'(e.thr));
        end
      end
      if (spikes_valid) begin
        if (spk_q.size() == 0) failNow("spikes_valid_unexpected");
        else checkOutput("spikes", 32'(spikes), 32'(spk_q.pop_front()));
      end
    end
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: got no finish expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    modelReset();
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    checkOutput("reset_ready", 32'(step_ready), 32'd1);
    checkOutput("reset_busy", 32'(busy), 32'd0);
    checkOutput("reset_spikes", 32'(spikes), 32'd0);
    checkOutput("reset_valid", 32'(spikes_valid), 32'd0);
    checkOutput("reset_count", 32'(spike_count), 32'd0);
    checkOutput("reset_membrane", 32'(int'(dp_last_membrane)), 32'd0);
    @(posedge clk); #1;

    // Latency/handshake profile of the first step right after reset.
    applyStimulus(1'b0, 2'd0, '0, 1'b1, 8'h3C, 3'd1, 4'd3);
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      checkOutput($sformatf("ready_cycle%0d", k), 32'(step_ready), (k == 6) ? 32'd1 : 32'd0);
      checkOutput($sformatf("valid_cycle%0d", k), 32'(spikes_valid), (k == 5) ? 32'd1 : 32'd0);
    end
    @(posedge clk); #1;

    // Three more back-to-back steps at threshold 3.
    for (int s = 0; s < 3; s++) applyStimulus(1'b0, 2'd0, '0, 1'b1, 8'(s * 17 + 5), 3'd2, 4'd3);
    applyStimulus(1'b0, 2'd0, '0, 1'b0, '0, 3'd2, 4'd3);
    @(negedge clk);
    checkOutput("step4_spikes", 32'(spikes), 32'hF);
    checkOutput("step4_membrane0", 32'(int'(dp_last_membrane)), 32'd4);
    @(posedge clk); #1;

    // Weight write during RUN is dropped; the same write in IDLE is used next step.
    applyStimulus(1'b0, 2'd0, '0, 1'b1, 8'h11, 3'd0, 4'd9);
    cfgDuringRun(2'd2, 8'hA5);
    applyStimulus(1'b1, 2'd2, 8'hA5, 1'b0, '0, 3'd0, 4'd9);
    applyStimulus(1'b0, 2'd0, '0, 1'b1, 8'h22, 3'd0, 4'd9);

    // Write and step in the same IDLE cycle.
    applyStimulus(1'b1, 2'd0, 8'hFF, 1'b1, 8'h33, 3'd5, 4'd2);

    // Abort a step with reset while neuron 2 is being evaluated.
    doReset();
    @(posedge clk); #1;
    applyStimulus(1'b0, 2'd0, '0, 1'b1, 8'h44, 3'd0, 4'd0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    modelReset();
    @(negedge clk);
    checkOutput("abort_ready", 32'(step_ready), 32'd1);
    checkOutput("abort_busy", 32'(busy), 32'd0);
    checkOutput("abort_spikes", 32'(spikes), 32'd0);
    checkOutput("abort_valid", 32'(spikes_valid), 32'd0);
    checkOutput("abort_membrane", 32'(int'(dp_last_membrane)), 32'd0);
    repeat (8) @(posedge clk);
    #1;

    // Threshold 0: every neuron fires on every step.
    for (int s = 0; s < 3; s++) applyStimulus(1'b0, 2'd0, '0, 1'b1, 8'h0F, 3'd0, 4'd0);

    // Randomized segments; resets keep the membranes well inside their range.
    for (int seg = 0; seg < 4; seg++) begin
      doReset();
      for (int s = 0; s < 10; s++) begin
        logic do_cfg;
        do_cfg = ($urandom_range(0, 2) == 0);
        applyStimulus(do_cfg, 2'($urandom_range(0, 3)), 8'($urandom),
                      1'b1, 8'($urandom), 3'($urandom), 4'($urandom_range(0, 12)));
        if ($urandom_range(0, 3) == 0) cfgDuringRun(2'($urandom_range(0, 3)), 8'($urandom));
        if ($urandom_range(0, 2) == 0) begin
          applyStimulus(1'b0, 2'd0, '0, 1'b0, '0, 3'd0, 4'd0);
          repeat ($urandom_range(0, 3)) @(posedge clk);
          #1;
        end
      end
    end

    repeat (12) @(posedge clk);
    #1;
    checkOutput("pending_dp", 32'(dp_q.size()), 32'd0);
    checkOutput("pending_spikes", 32'(spk_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
